// File: rtl/divider_sequencer.sv
// Control sequencer for a WIDTH-slice restoring divider array.
// It runs load, WIDTH shift/subtract pairs and result capture, and flags divide-by-zero.
module divider_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic Clock,
   input  logic nReset,
   input  logic Start,
   input  logic Abort,
   input  logic nBorrowOut,
   input  logic DivisorZero,
   output logic EnableOp1,
   output logic EnableOp2,
   output logic LoadA,
   output logic LoadB,
   output logic LoadM,
   output logic EnableSub,
   output logic EnableZero,
   output logic Increment,
   output logic LoadResult,
   output logic nBorrowIn,
   output logic Busy,
   output logic Done,
   output logic DivZero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SHIFT  = 3'd2,
      SUB    = 3'd3,
      RESULT = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t        state;
   logic [CW-1:0] count;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state   <= IDLE;
         count   <= '0;
         DivZero <= 1'b0;
      end else if (Abort && state != IDLE) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               // Abort in IDLE only suppresses a simultaneous Start
               if (Start && !Abort) begin
                  state   <= LOAD;
                  DivZero <= 1'b0;
               end
            end
            LOAD: begin
               count <= '0;
               if (DivisorZero) begin
                  state   <= DONE;
                  DivZero <= 1'b1;
               end else begin
                  state <= SHIFT;
               end
            end
            SHIFT: state <= SUB;
            SUB: begin
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) state <= RESULT;
               else                         state <= SHIFT;
            end
            RESULT:  state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Moore decode; only LoadA/Increment in SUB follow the live borrow
   assign EnableOp1  = (state == LOAD);
   assign EnableOp2  = (state == LOAD);
   assign LoadM      = (state == LOAD);
   assign EnableZero = (state == LOAD);
   assign LoadB      = (state == LOAD) || (state == SHIFT);
   assign LoadA      = (state == LOAD) || (state == SHIFT) || ((state == SUB) && nBorrowOut);
   assign EnableSub  = (state == SUB);
   assign Increment  = (state == SUB) && nBorrowOut;
   assign LoadResult = (state == RESULT);
   assign Done       = (state == DONE);
   assign Busy       = (state != IDLE);
   assign nBorrowIn  = 1'b1;

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer with a behavioural 8-slice datapath model.
module tb_divider_sequencer;

   localparam int W = 8;

   logic Clock = 1'b0;
   logic nReset, Start, Abort, nBorrowOut, DivisorZero;
   logic EnableOp1, EnableOp2, LoadA, LoadB, LoadM, EnableSub, EnableZero;
   logic Increment, LoadResult, nBorrowIn, Busy, Done, DivZero;

   divider_sequencer #(.WIDTH(W)) dut (
      .Clock(Clock), .nReset(nReset), .Start(Start), .Abort(Abort),
      .nBorrowOut(nBorrowOut), .DivisorZero(DivisorZero),
      .EnableOp1(EnableOp1), .EnableOp2(EnableOp2), .LoadA(LoadA), .LoadB(LoadB),
      .LoadM(LoadM), .EnableSub(EnableSub), .EnableZero(EnableZero),
      .Increment(Increment), .LoadResult(LoadResult), .nBorrowIn(nBorrowIn),
      .Busy(Busy), .Done(Done), .DivZero(DivZero)
   );

   always #5 Clock = ~Clock;

   // slice array model: A carries one guard bit for the post-shift compare
   logic [W:0]   ma;
   logic [W-1:0] mb, mm, dividend, divisor, q, r;
   logic [8:0]   strb;

   assign DivisorZero = (divisor == '0);
   assign nBorrowOut  = (ma >= {1'b0, mm});
   assign strb = {EnableOp1, EnableOp2, LoadA, LoadB, LoadM, EnableSub, EnableZero, Increment, LoadResult};

   always @(posedge Clock) begin
      if (LoadResult) begin
         q <= mb;
         r <= ma[W-1:0];
      end
      if (EnableZero && LoadA) begin
         ma <= '0;
         mb <= dividend;
         mm <= divisor;
      end else if (EnableSub) begin
         if (LoadA) ma <= ma - {1'b0, mm};
         if (Increment) mb[0] <= 1'b1;
      end else if (LoadA && LoadB) begin
         ma <= {ma[W-1:0], mb[W-1]};
         mb <= {mb[W-2:0], 1'b0};
      end
   end

   int checks = 0;
   int errors = 0;
   int n_done, done_at, lr_at, n_sub, sub_hits;
   int busy_at [0:40];
   int strb_at [0:40];
   int dz_at   [0:40];

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Start sampled at edge 0; cycle c is the period following edge c-1
   task automatic run(input int dd, input int dv, input int ab, input int s1, input int s2, input int ncyc);
      n_done = 0; done_at = -1; lr_at = -1; n_sub = 0; sub_hits = 0;
      dividend = dd[W-1:0];
      divisor  = dv[W-1:0];
      @(negedge Clock);
      Start = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge Clock);
         if (Done) begin n_done++; done_at = c; end
         if (LoadResult) lr_at = c;
         if (EnableSub) begin
            n_sub++;
            if (LoadA || Increment) sub_hits++;
         end
         busy_at[c] = int'(Busy);
         strb_at[c] = int'(strb);
         dz_at[c]   = int'(DivZero);
         Start = (c == s1) || (c == s2);
         Abort = (c == ab);
      end
      Start = 1'b0;
      Abort = 1'b0;
   endtask

   initial begin
      nReset = 1'b0; Start = 1'b0; Abort = 1'b0;
      dividend = '0; divisor = 8'd1;
      #22;
      chk("rst_strobes", int'(strb), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_divzero", int'(DivZero), 0);
      chk("rst_nborrowin", int'(nBorrowIn), 1);
      @(negedge Clock);
      nReset = 1'b1;

      // 200/7
      run(200, 7, -1, -1, -1, 22);
      chk("n_lr_cycle", lr_at, 18);
      chk("n_done_cycle", done_at, 19);
      chk("n_done_count", n_done, 1);
      chk("n_sub_count", n_sub, 8);
      chk("n_quotient", int'(q), 28);
      chk("n_remainder", int'(r), 4);
      chk("n_divzero", dz_at[19], 0);
      chk("n_load_strobes", strb_at[1], 9'b111110100);
      chk("n_shift_strobes", strb_at[2], 9'b001100000);
      chk("n_busy_after", busy_at[20], 0);
      chk("n_borrowin", int'(nBorrowIn), 1);

      // Start pulses while busy are dropped
      run(200, 7, -1, 3, 10, 22);
      chk("bz_done_count", n_done, 1);
      chk("bz_done_cycle", done_at, 19);
      chk("bz_quotient", int'(q), 28);

      // divide-by-zero
      run(5, 0, -1, -1, -1, 4);
      chk("dz_done_cycle", done_at, 2);
      chk("dz_flag", dz_at[2], 1);
      chk("dz_no_result", lr_at, -1);
      chk("dz_no_sub", n_sub, 0);
      chk("dz_no_shift", strb_at[2] & 9'b001100000, 0);
      chk("dz_held_idle", dz_at[4], 1);

      // 1/255: every trial subtract borrows; also checks DivZero clears on Start
      run(1, 255, -1, -1, -1, 22);
      chk("dz_cleared", dz_at[1], 0);
      chk("rs_sub_hits", sub_hits, 0);
      chk("rs_sub_count", n_sub, 8);
      chk("rs_quotient", int'(q), 0);
      chk("rs_remainder", int'(r), 1);

      // abort in cycle 7, restart in cycle 8
      run(200, 7, 7, 8, -1, 30);
      chk("ab_busy8", busy_at[8], 0);
      chk("ab_strobes8", strb_at[8], 0);
      chk("ab_load9", strb_at[9], 9'b111110100);
      chk("ab_done_count", n_done, 1);
      chk("ab_done_cycle", done_at, 27);
      chk("ab_quotient", int'(q), 28);

      // Start and Abort together in IDLE
      @(negedge Clock);
      Start = 1'b1; Abort = 1'b1;
      @(negedge Clock);
      Start = 1'b0; Abort = 1'b0;
      chk("sa_idle_busy", int'(Busy), 0);

      // reset during 5th SUB (cycle 11)
      run(200, 7, -1, -1, -1, 11);
      chk("mr_in_sub", strb_at[11] & 9'b000001000, 9'b000001000);
      nReset = 1'b0;
      #1;
      chk("mr_strobes", int'(strb), 0);
      chk("mr_busy", int'(Busy), 0);
      @(negedge Clock);
      nReset = 1'b1;
      run(200, 7, -1, -1, -1, 22);
      chk("mr_load", strb_at[1], 9'b111110100);
      chk("mr_done_cycle", done_at, 19);
      chk("mr_quotient", int'(q), 28);
      chk("mr_remainder", int'(r), 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/divider_sequencer.md
# divider_sequencer

Control sequencer for the 8-slice restoring divider array built from `bitslice`. It accepts a one-cycle `Start` request and drives the slice control lines through load, shift/subtract iterations and result capture. It evaluates the MSB slice's `nBorrowOut` each iteration to choose between commit and restore. It reports completion, busy and divide-by-zero to the surrounding system and sits between the host register interface and the bitslice array.

## Interface
- WIDTH, 8, number of bitslices and division iterations; legal range 2..16.
- Clock  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Start  in  1  begin a division; sampled only in IDLE.
- Abort  in  1  synchronous abort; returns the sequencer to IDLE.
- nBorrowOut  in  1  borrow chain output of the MSB slice; 0 means the trial subtract went negative.
- DivisorZero  in  1  high when the divisor operand bus is all zero; sampled in LOAD.
- EnableOp1, EnableOp2  out  1 each  gate the dividend and divisor operands onto the slices.
- LoadA, LoadB, LoadM  out  1 each  slice register load strobes.
- EnableSub  out  1  selects the subtract path in the slices.
- EnableZero  out  1  forces zero into A, which holds the partial remainder.
- Increment  out  1  sets the quotient LSB in B.
- LoadResult  out  1  captures the quotient and remainder into the output registers.
- nBorrowIn  out  1  borrow into the LSB slice; constant 1.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- DivZero  out  1  held with `Done`; set on divide-by-zero, cleared on the next `Start`.

## Operation
- Reset values:
  - State IDLE and iteration counter 0.
  - All control outputs 0, except `nBorrowIn` = 1.
  - `Busy`, `Done` and `DivZero` are 0.
- All control outputs are Moore outputs decoded from the state register. The exceptions are `LoadA` and `Increment` in SUB, which are combinational from `nBorrowOut`.
- IDLE:
  - All strobes are 0.
  - `Start`=1 → LOAD; `DivZero` clears.
- LOAD (1 cycle):
  - Asserted: `EnableOp1`, `EnableOp2`, `LoadA`, `LoadB`, `LoadM`, `EnableZero`.
  - Effect: A=0, B=dividend, M=divisor; counter is cleared.
  - `DivisorZero`=1 → DONE with `DivZero` set, which skips the iterations and RESULT.
  - Otherwise → SHIFT.
- SHIFT (1 cycle):
  - Asserted: `LoadA`, `LoadB` only, with `EnableSub`=0.
  - Effect: the slices shift A:B left by one bit.
  - Next state: SUB.
- SUB (1 cycle):
  - `EnableSub`=1.
  - `LoadA` = `nBorrowOut` and `Increment` = `nBorrowOut`.
    - Borrow (`nBorrowOut`=0): A is not loaded, which restores the partial remainder, and the quotient bit is 0.
  - Counter increments.
  - Counter reaches WIDTH after the increment → RESULT; otherwise → SHIFT.
- RESULT (1 cycle): `LoadResult`=1, then → DONE.
- DONE (1 cycle): `Done`=1, then → IDLE.
- `Start` is ignored while `Busy`=1, and there is no queueing.
- `Abort`=1 in any non-IDLE state: next state is IDLE, all strobes drop next cycle, and there is no `Done` pulse. `Abort` wins over all other transitions.
- `Abort` in IDLE has no effect. `Start` and `Abort` together in IDLE: `Abort` wins and the sequencer stays in IDLE.
- The counter is WIDTH-wide enough to hold the value WIDTH and never wraps during an operation.

## Timing
- Edge 0 samples `Start`=1 in IDLE. The phases follow in successive cycles:
  - LOAD in cycle 1.
  - SHIFT/SUB pairs in cycles 2 .. 2·WIDTH+1.
  - RESULT in cycle 2·WIDTH+2.
  - DONE in cycle 2·WIDTH+3.
- For WIDTH=8: `LoadResult` is high in cycle 18 and `Done` is high in cycle 19.
- For divide-by-zero, `Done` is high in cycle 2.
- `Busy` rises with LOAD and falls after DONE. A new `Start` is accepted in the first IDLE cycle after DONE, which gives back-to-back throughput of one division per 2·WIDTH+4 cycles.
- `nBorrowOut` must be settled within the SUB cycle; it is not registered.
- `nReset` asserted mid-operation forces the reset values immediately, without waiting for `Clock`.

## Test plan
- Reset mid-iteration:
  - Stimulus: pull `nReset` low during the 5th SUB.
  - Required: all strobes and `Busy` go to 0 asynchronously; after release, `Start` begins a fresh LOAD.
- Normal divide with a slice behavioural model, 200/7:
  - Required: `nBorrowOut` pattern gives quotient 28 and remainder 4.
  - Required: `LoadResult` is high in cycle 18 and `Done` in cycle 19; `DivZero`=0.
- Divide-by-zero:
  - Stimulus: `DivisorZero`=1 in LOAD.
  - Required: no SHIFT/SUB and no `LoadResult`; `Done`=1 and `DivZero`=1 in cycle 2.
  - Required: `DivZero` clears on the next `Start`.
- Abort:
  - Stimulus: `Abort` in cycle 7.
  - Required: IDLE from cycle 8, no `Done` pulse, and `Start` accepted in cycle 8.
- `Start` while busy:
  - Stimulus: pulse `Start` in cycles 3 and 10.
  - Required: ignored; exactly one `Done`, in cycle 19.
- Restore check, 1/255:
  - Required: every SUB sees `nBorrowOut`=0, so `LoadA` and `Increment` are never asserted in SUB.
  - Required: quotient 0 and remainder 1.
